// File: rtl/rnbip_pkg.sv
// Shared types and constants for the fetch stage: FSM states, redirect target
// select codes, bubble/reset constants and the flag-check helper.
package rnbip_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        STALL = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_NPC = 2'b00,
        SEL_REL = 2'b01,
        SEL_STK = 2'b10,
        SEL_ABS = 2'b11
    } pc_sel_t;

    localparam logic [15:0] NOP_SEG  = 16'h0000;
    localparam logic [7:0]  RESET_PC = 8'h00;

    // Bit positions inside alu_flags = {C,Z,S,P}
    localparam int FLAG_P = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

    // Segment bits [9:8] pick a flag, bit 10 inverts the test.
    function automatic logic flag_check(input logic [3:0] flags, input logic [15:0] seg);
        return flags[seg[9:8]] ^ seg[10];
    endfunction

endpackage

// File: rtl/pipe_fetch_stage_if.sv
// Bundle of ROM, redirect/stall control and CCG1-facing signals around the fetch stage.
// master = fetch stage side, slave = ROM plus downstream pipeline side.
interface pipe_fetch_stage_if;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        stall;
    logic        L_PC;
    logic        S11;
    logic        S10;
    logic [7:0]  NPC_in;
    logic [7:0]  OR2;
    logic [7:0]  stack_data;
    logic [3:0]  alu_flags;
    logic [15:0] segment;
    logic        FL;
    logic [7:0]  PC_in;
    logic        seg_valid;
    logic        flush;

    modport master (
        output imem_addr, imem_rd,
        input  imem_data,
        input  stall, L_PC, S11, S10, NPC_in, OR2, stack_data, alu_flags,
        output segment, FL, PC_in, seg_valid, flush
    );

    modport slave (
        input  imem_addr, imem_rd,
        output imem_data,
        output stall, L_PC, S11, S10, NPC_in, OR2, stack_data, alu_flags,
        input  segment, FL, PC_in, seg_valid, flush
    );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational redirect target mux; the relative form wraps modulo 256.
module next_pc_sel
    import rnbip_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [7:0] npc_in,
    input  logic [7:0] or2,
    input  logic [7:0] stack_data,
    output logic [7:0] target
);

    always_comb begin
        target = npc_in;
        case (pc_sel_t'(sel))
            SEL_NPC: target = npc_in;
            SEL_REL: target = npc_in + or2;
            SEL_STK: target = stack_data;
            SEL_ABS: target = or2;
            default: target = npc_in;
        endcase
    end

endmodule

// File: rtl/pipe_fetch_stage.sv
// Fetch stage: owns the PC, reads the 1-cycle sync ROM, applies redirects with
// wrong-path squash, and parks returning data in a 1-entry skid buffer on stall.
module pipe_fetch_stage #(
    parameter logic [7:0]  RESET_PC = rnbip_pkg::RESET_PC,
    parameter logic [15:0] NOP_SEG  = rnbip_pkg::NOP_SEG
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_fetch_stage_if.master  bus
);
    import rnbip_pkg::*;

    fetch_state_t state_reg;
    logic [1:0]   cnt_reg;
    logic [7:0]   pc_reg;
    logic         rd_v_reg;
    logic [7:0]   rd_addr_reg;
    logic [15:0]  hold_seg_reg;
    logic [7:0]   hold_pc_in_reg;
    logic         hold_fl_reg;
    logic         hold_v_reg;
    logic [15:0]  segment_reg;
    logic         fl_reg;
    logic [7:0]   pc_in_reg;
    logic         seg_valid_reg;
    logic         flush_reg;

    logic         rd_en;
    logic [7:0]   target;
    logic         arrive_fl;

    // A redirect always fetches, even when stall is raised in the same cycle.
    assign rd_en     = rst_n & (bus.L_PC | ~bus.stall);
    assign arrive_fl = flag_check(bus.alu_flags, bus.imem_data);

    assign bus.imem_addr = pc_reg;
    assign bus.imem_rd   = rd_en;
    assign bus.segment   = segment_reg;
    assign bus.FL        = fl_reg;
    assign bus.PC_in     = pc_in_reg;
    assign bus.seg_valid = seg_valid_reg;
    assign bus.flush     = flush_reg;

    next_pc_sel u_next_pc_sel (
        .sel        ({bus.S11, bus.S10}),
        .npc_in     (bus.NPC_in),
        .or2        (bus.OR2),
        .stack_data (bus.stack_data),
        .target     (target)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= BOOT;
            cnt_reg        <= 2'd0;
            pc_reg         <= RESET_PC;
            rd_v_reg       <= 1'b0;
            rd_addr_reg    <= 8'd0;
            hold_seg_reg   <= NOP_SEG;
            hold_pc_in_reg <= 8'd0;
            hold_fl_reg    <= 1'b0;
            hold_v_reg     <= 1'b0;
            segment_reg    <= NOP_SEG;
            fl_reg         <= 1'b0;
            pc_in_reg      <= 8'd0;
            seg_valid_reg  <= 1'b0;
            flush_reg      <= 1'b0;
        end else begin
            flush_reg   <= bus.L_PC;
            // The read issued alongside a redirect is wrong-path; never let it land.
            rd_v_reg    <= rd_en & ~bus.L_PC;
            rd_addr_reg <= pc_reg;

            if (bus.L_PC) begin
                pc_reg <= target;
            end else if (rd_en) begin
                pc_reg <= pc_reg + 8'd1;
            end

            if (bus.L_PC) begin
                segment_reg   <= NOP_SEG;
                seg_valid_reg <= 1'b0;
                hold_v_reg    <= 1'b0;
            end else if (bus.stall) begin
                if (rd_v_reg) begin
                    hold_seg_reg   <= bus.imem_data;
                    hold_pc_in_reg <= rd_addr_reg + 8'd1;
                    hold_fl_reg    <= arrive_fl;
                    hold_v_reg     <= 1'b1;
                end
            end else if (hold_v_reg) begin
                segment_reg   <= hold_seg_reg;
                pc_in_reg     <= hold_pc_in_reg;
                fl_reg        <= hold_fl_reg;
                seg_valid_reg <= 1'b1;
                hold_v_reg    <= 1'b0;
            end else if (rd_v_reg) begin
                segment_reg   <= bus.imem_data;
                pc_in_reg     <= rd_addr_reg + 8'd1;
                fl_reg        <= arrive_fl;
                seg_valid_reg <= 1'b1;
            end else begin
                segment_reg   <= NOP_SEG;
                seg_valid_reg <= 1'b0;
            end

            if (bus.L_PC) begin
                state_reg <= FLUSH;
                cnt_reg   <= 2'd2;
            end else begin
                case (state_reg)
                    BOOT:    if (!bus.stall) state_reg <= RUN;
                    RUN:     if (bus.stall)  state_reg <= STALL;
                    STALL:   if (!bus.stall) state_reg <= RUN;
                    FLUSH: begin
                        if (!bus.stall) begin
                            if (cnt_reg == 2'd1) begin
                                state_reg <= RUN;
                                cnt_reg   <= 2'd0;
                            end else begin
                                cnt_reg <= cnt_reg - 2'd1;
                            end
                        end
                    end
                    default: state_reg <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Self-checking bench for pipe_fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, checked against a stream-level reference model.
module tb_pipe_fetch_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_fetch_stage_if bus ();

    pipe_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction ROM with one cycle of read latency
    logic [15:0] mem [0:255];
    logic [15:0] rom_q = 16'h0000;
    always @(posedge clk) if (bus.imem_rd) rom_q <= mem[bus.imem_addr];
    assign bus.imem_data = rom_q;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: outputs after each edge, plus the pending fetch stream
    logic [15:0] exp_seg;
    logic        exp_valid;
    logic [7:0]  exp_pc_in;
    logic        exp_fl;
    logic        exp_flush;
    int          bubbles;
    logic [7:0]  next_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        logic [7:0]  tgt;
        logic [15:0] w;
        if (!rst_n) begin
            exp_seg = 16'h0000; exp_valid = 1'b0; exp_pc_in = 8'h00;
            exp_fl = 1'b0; exp_flush = 1'b0;
            bubbles = 1; next_addr = 8'h00;
        end else if (bus.L_PC) begin
            case ({bus.S11, bus.S10})
                2'b00:   tgt = bus.NPC_in;
                2'b01:   tgt = bus.NPC_in + bus.OR2;
                2'b10:   tgt = bus.stack_data;
                default: tgt = bus.OR2;
            endcase
            exp_seg = 16'h0000; exp_valid = 1'b0; exp_flush = 1'b1;
            bubbles = 1; next_addr = tgt;
        end else begin
            exp_flush = 1'b0;
            if (!bus.stall) begin
                if (bubbles > 0) begin
                    bubbles--;
                    exp_seg = 16'h0000; exp_valid = 1'b0;
                end else begin
                    w = mem[next_addr];
                    exp_seg   = w;
                    exp_valid = 1'b1;
                    exp_pc_in = next_addr + 8'd1;
                    exp_fl    = bus.alu_flags[w[9:8]] ^ w[10];
                    next_addr = next_addr + 8'd1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("segment",   32'(bus.segment),   32'(exp_seg));
        chk("seg_valid", 32'(bus.seg_valid), 32'(exp_valid));
        chk("PC_in",     32'(bus.PC_in),     32'(exp_pc_in));
        chk("FL",        32'(bus.FL),        32'(exp_fl));
        chk("flush",     32'(bus.flush),     32'(exp_flush));
        $display("t=%0t rst_n=%0d stall=%0d L_PC=%0d seg=%h v=%0d PC_in=%h FL=%0d flush=%0d",
                 $time, rst_n, bus.stall, bus.L_PC, bus.segment, bus.seg_valid,
                 bus.PC_in, bus.FL, bus.flush);
    endtask

    task automatic drive(input logic st, input logic lpc, input logic [1:0] s,
                         input logic [7:0] npc, input logic [7:0] or2, input logic [7:0] stk);
        bus.stall = st; bus.L_PC = lpc; bus.S11 = s[1]; bus.S10 = s[0];
        bus.NPC_in = npc; bus.OR2 = or2; bus.stack_data = stk;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        logic prev_stall;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] hi;
            hi = 8'($urandom);
            mem[i] = {hi, 8'(i)};
        end
        bubbles = 1; next_addr = 8'h00;
        exp_seg = 16'h0; exp_valid = 1'b0; exp_pc_in = 8'h0; exp_fl = 1'b0; exp_flush = 1'b0;
        idle();
        bus.alu_flags = 4'($urandom);
        rst_n = 1'b0;
        #2;
        chk("imem_rd_in_reset", 32'(bus.imem_rd), 32'd0);
        tick(); tick();

        // Boot: first valid segment on the second edge after release
        rst_n = 1'b1;
        repeat (9) tick();

        // Absolute redirect to 0x40
        drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h40, 8'h00); tick();
        idle(); repeat (5) tick();

        // Relative redirect wrapping: F0 + 20 = 10
        drive(1'b0, 1'b1, 2'b01, 8'hF0, 8'h20, 8'h00); tick();
        idle(); repeat (4) tick();

        // PC wrap FF -> 00
        drive(1'b0, 1'b1, 2'b11, 8'h00, 8'hFD, 8'h00); tick();
        idle(); repeat (6) tick();

        // Three-cycle stall mid-run
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00); repeat (3) tick();
        idle(); repeat (5) tick();

        // Redirect and stall together: redirect to stack_data wins
        drive(1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'h33); tick();
        idle(); repeat (4) tick();

        // Refetch at NPC_in
        drive(1'b0, 1'b1, 2'b00, 8'h9A, 8'h55, 8'h00); tick();
        idle(); repeat (4) tick();

        // Stall during the flush window
        drive(1'b0, 1'b1, 2'b11, 8'h00, 8'hC0, 8'h00); tick();
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00); repeat (2) tick();
        idle(); repeat (4) tick();

        // Reset asserted during flush
        drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h77, 8'h00); tick();
        idle(); rst_n = 1'b0; tick();
        rst_n = 1'b1; repeat (4) tick();

        // Random traffic; flags only change when no skid entry can be pending
        prev_stall = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic st, lpc;
            st  = ($urandom_range(0, 3) == 0);
            lpc = ($urandom_range(0, 11) == 0);
            drive(st, lpc, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if (!prev_stall) bus.alu_flags = 4'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            prev_stall = st;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
